// File: rtl/imem_arb.sv
// Instruction-memory arbiter: a fetch port and a debug/loader port share one
// single-cycle read port. Define IMEM_ARB_STATS_EN to add per-requester grant counters.
module imem_arb #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              f_req_i,
  input  logic [ADDR_W-1:0] f_adr_i,
  output logic              f_gnt_o,
  output logic              f_valid_o,
  output logic [DATA_W-1:0] f_inst_o,
  input  logic              d_req_i,
  input  logic [ADDR_W-1:0] d_adr_i,
  output logic              d_gnt_o,
  output logic              d_valid_o,
  output logic [DATA_W-1:0] d_inst_o,
  output logic [ADDR_W-1:0] mem_adr_o,
  input  logic [DATA_W-1:0] mem_instruction_i,
  output logic              busy_o
`ifdef IMEM_ARB_STATS_EN
  ,
  output logic [15:0]       f_cnt_o,
  output logic [15:0]       d_cnt_o
`endif
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    F_RD = 2'd1,
    D_RD = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [SW-1:0]     starve_cnt_q, starve_cnt_d;
  logic [ADDR_W-1:0] mem_adr_q, mem_adr_d;
  logic              f_valid_q, d_valid_q;
  logic [DATA_W-1:0] f_inst_q, d_inst_q;
  logic              starving;

  // Every edge is an arbitration edge, so a grant can follow a grant directly.
  always_comb begin
    state_d      = IDLE;
    mem_adr_d    = mem_adr_q;
    starve_cnt_d = '0;
    starving     = d_req_i && (starve_cnt_q == STARVE_LIM);

    if (f_req_i && !starving) begin
      state_d   = F_RD;
      mem_adr_d = f_adr_i;
    end else if (d_req_i) begin
      state_d   = D_RD;
      mem_adr_d = d_adr_i;
    end

    if (d_req_i && state_d == F_RD && starve_cnt_q != STARVE_LIM) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      mem_adr_q    <= '0;
      f_valid_q    <= 1'b0;
      d_valid_q    <= 1'b0;
      f_inst_q     <= '0;
      d_inst_q     <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      mem_adr_q    <= mem_adr_d;
      f_valid_q    <= (state_q == F_RD);
      d_valid_q    <= (state_q == D_RD);
      // The edge leaving a read state captures that access's data.
      if (state_q == F_RD) f_inst_q <= mem_instruction_i;
      if (state_q == D_RD) d_inst_q <= mem_instruction_i;
    end
  end

`ifdef IMEM_ARB_STATS_EN
  logic [15:0] f_cnt_q, d_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      f_cnt_q <= '0;
      d_cnt_q <= '0;
    end else begin
      if (state_d == F_RD && f_cnt_q != 16'hFFFF) f_cnt_q <= f_cnt_q + 16'd1;
      if (state_d == D_RD && d_cnt_q != 16'hFFFF) d_cnt_q <= d_cnt_q + 16'd1;
    end
  end

  assign f_cnt_o = f_cnt_q;
  assign d_cnt_o = d_cnt_q;
`endif

  assign f_gnt_o   = (state_q == F_RD);
  assign d_gnt_o   = (state_q == D_RD);
  assign busy_o    = (state_q != IDLE);
  assign f_valid_o = f_valid_q;
  assign d_valid_o = d_valid_q;
  assign f_inst_o  = f_inst_q;
  assign d_inst_o  = d_inst_q;
  assign mem_adr_o = mem_adr_q;

endmodule

// File: tb/tb_imem_arb.sv
// Testbench for imem_arb: directed stimulus with a transaction-level model of
// the arbiter and memory, checked on every falling edge.
module tb_imem_arb;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 4;

  logic              clk;
  logic              rst_n;
  logic              f_req, d_req;
  logic [ADDR_W-1:0] f_adr, d_adr;
  logic              f_gnt, f_valid, d_gnt, d_valid, busy;
  logic [DATA_W-1:0] f_inst, d_inst, mem_instruction;
  logic [ADDR_W-1:0] mem_adr;
`ifdef IMEM_ARB_STATS_EN
  logic [15:0]       f_cnt, d_cnt;
`endif

  int total = 0;
  int bad   = 0;

  imem_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .f_req_i(f_req), .f_adr_i(f_adr), .f_gnt_o(f_gnt), .f_valid_o(f_valid), .f_inst_o(f_inst),
    .d_req_i(d_req), .d_adr_i(d_adr), .d_gnt_o(d_gnt), .d_valid_o(d_valid), .d_inst_o(d_inst),
    .mem_adr_o(mem_adr), .mem_instruction_i(mem_instruction), .busy_o(busy)
`ifdef IMEM_ARB_STATS_EN
    , .f_cnt_o(f_cnt), .d_cnt_o(d_cnt)
`endif
  );

  // Instruction memory contents: word 2 is a real instruction, others are tagged by address.
  function automatic logic [DATA_W-1:0] memWord(input logic [ADDR_W-1:0] a);
    if (a == 2) return 32'h00A00093;
    return {16'hC0DE, a[15:0]};
  endfunction

  assign mem_instruction = memWord(mem_adr);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: who owns the memory this cycle, which address, and
  // how many fetch grants debug has waited through.
  int                mOwner = 0;
  int                mStarve = 0;
  int                nextOwner;
  logic [ADDR_W-1:0] mAdr = '0;
  logic              mFValid = 1'b0, mDValid = 1'b0;
  logic [DATA_W-1:0] mFInst = '0, mDInst = '0;
  logic [15:0]       mFCnt = '0, mDCnt = '0;

  function automatic int pickWinner(input logic fr, input logic dr, input int starve);
    if (fr && !(dr && starve >= STARVE_MAX)) return 1;
    if (dr) return 2;
    return 0;
  endfunction

  assign nextOwner = pickWinner(f_req, d_req, mStarve);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mOwner  <= 0;
      mStarve <= 0;
      mAdr    <= '0;
      mFValid <= 1'b0;
      mDValid <= 1'b0;
      mFInst  <= '0;
      mDInst  <= '0;
      mFCnt   <= '0;
      mDCnt   <= '0;
    end else begin
      mFValid <= (mOwner == 1);
      mDValid <= (mOwner == 2);
      if (mOwner == 1) mFInst <= memWord(mAdr);
      if (mOwner == 2) mDInst <= memWord(mAdr);
      mOwner <= nextOwner;
      if (nextOwner == 1) mAdr <= f_adr;
      if (nextOwner == 2) mAdr <= d_adr;
      mStarve <= (d_req && nextOwner == 1) ? mStarve + 1 : 0;
      if (nextOwner == 1 && mFCnt != 16'hFFFF) mFCnt <= mFCnt + 16'd1;
      if (nextOwner == 2 && mDCnt != 16'hFFFF) mDCnt <= mDCnt + 16'd1;
    end
  end

  // Compare the DUT against the model on every falling edge.
  always @(negedge clk) begin
    checkOutput("f_gnt",   f_gnt,   mOwner == 1);
    checkOutput("d_gnt",   d_gnt,   mOwner == 2);
    checkOutput("busy",    busy,    mOwner != 0);
    checkOutput("mem_adr", mem_adr, mAdr);
    checkOutput("f_valid", f_valid, mFValid);
    checkOutput("d_valid", d_valid, mDValid);
    checkOutput("f_inst",  f_inst,  mFInst);
    checkOutput("d_inst",  d_inst,  mDInst);
    checkOutput("valid_excl", f_valid && d_valid, 1'b0);
`ifdef IMEM_ARB_STATS_EN
    checkOutput("f_cnt", f_cnt, mFCnt);
    checkOutput("d_cnt", d_cnt, mDCnt);
`endif
  end

  // Collects fetch results during the streaming test.
  logic              collect = 1'b0;
  int                cyc = 0;
  logic [DATA_W-1:0] got[$];
  int                gotCyc[$];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (collect && f_valid) begin
      got.push_back(f_inst);
      gotCyc.push_back(cyc);
    end
  end

  task automatic applyStimulus(input logic fr, input logic [ADDR_W-1:0] fa,
                               input logic dr, input logic [ADDR_W-1:0] da);
    f_req = fr;
    f_adr = fa;
    d_req = dr;
    d_adr = da;
  endtask

  initial begin
    int grants;
    int fg;
    logic dSeen;

    rst_n = 1'b0;
    applyStimulus(1'b1, '0, 1'b0, '0);
    repeat (3) @(negedge clk);
    checkOutput("rst_f_gnt", f_gnt, 1'b0);
    checkOutput("rst_f_valid", f_valid, 1'b0);
    checkOutput("rst_mem_adr", mem_adr, 0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rel_f_gnt", f_gnt, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, '0);
    repeat (2) @(negedge clk);

    // Single fetch of word 2
    applyStimulus(1'b1, 2, 1'b0, '0);
    @(negedge clk);
    checkOutput("single_gnt", f_gnt, 1'b1);
    checkOutput("single_adr", mem_adr, 2);
    applyStimulus(1'b0, '0, 1'b0, '0);
    @(negedge clk);
    checkOutput("single_valid", f_valid, 1'b1);
    checkOutput("single_inst", f_inst, 32'h00A00093);
    repeat (2) @(negedge clk);

    // Streaming fetch of words 0..3
    collect = 1'b1;
    applyStimulus(1'b1, 0, 1'b0, '0);
    grants = 0;
    for (int k = 0; k < 20 && grants < 4; k++) begin
      @(negedge clk);
      if (f_gnt) begin
        grants++;
        if (grants == 4) f_req = 1'b0;
        else f_adr = grants;
      end
    end
    checkOutput("stream_grants", grants, 4);
    repeat (3) @(negedge clk);
    collect = 1'b0;
    checkOutput("stream_count", got.size(), 4);
    if (got.size() == 4) begin
      checkOutput("stream_w0", got[0], 32'hC0DE0000);
      checkOutput("stream_w1", got[1], 32'hC0DE0001);
      checkOutput("stream_w2", got[2], 32'h00A00093);
      checkOutput("stream_w3", got[3], 32'hC0DE0003);
      checkOutput("stream_consec", gotCyc[3] - gotCyc[0], 3);
    end

    // Starvation: fetch held, debug waits exactly STARVE_MAX fetch grants
    applyStimulus(1'b1, 8, 1'b1, 5);
    fg = 0;
    dSeen = 1'b0;
    for (int k = 0; k < 20 && !dSeen; k++) begin
      @(negedge clk);
      if (f_gnt) fg++;
      if (d_gnt) begin
        dSeen = 1'b1;
        d_req = 1'b0;
      end
    end
    checkOutput("starve_dseen", dSeen, 1'b1);
    checkOutput("starve_fgrants", fg, 4);
    @(negedge clk);
    checkOutput("starve_resume", f_gnt, 1'b1);
    checkOutput("starve_dvalid", d_valid, 1'b1);
    checkOutput("starve_dinst", d_inst, 32'hC0DE0005);
    f_req = 1'b0;
`ifdef IMEM_ARB_STATS_EN
    checkOutput("stats_f_cnt", f_cnt, 11);
    checkOutput("stats_d_cnt", d_cnt, 1);
`endif
    repeat (3) @(negedge clk);

    // Reset in the middle of a debug read
    applyStimulus(1'b0, '0, 1'b1, 7);
    @(negedge clk);
    checkOutput("mid_dgnt", d_gnt, 1'b1);
    d_req = 1'b0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    checkOutput("mid_dvalid", d_valid, 1'b0);
    checkOutput("mid_dinst", d_inst, 0);
    checkOutput("mid_busy", busy, 1'b0);
    rst_n = 1'b1;
    applyStimulus(1'b0, '0, 1'b1, 9);
    @(negedge clk);
    checkOutput("post_dgnt", d_gnt, 1'b1);
    d_req = 1'b0;
    @(negedge clk);
    checkOutput("post_dvalid", d_valid, 1'b1);
    checkOutput("post_dinst", d_inst, 32'hC0DE0009);
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
